// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I load/store sequencer for a word-wide data memory
// Sub-word stores use read-modify-write; loads extract a lane and sign/zero extend.
module dmem_lsu #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clkin,
    input  logic        nrst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_we_in,
    input  logic [2:0]  req_funct3_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    output logic        resp_valid_out,
    input  logic        resp_ready_in,
    output logic [31:0] resp_rdata_out,
    output logic        resp_err_out,
    output logic        mem_wr_en_out,
    output logic [31:0] mem_wr_addr_out,
    output logic [31:0] mem_wr_data_out,
    output logic [31:0] mem_rd_addr_out,
    input  logic [31:0] mem_rd_data_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_ERR,
        S_RESP
    } state_t;

    state_t      state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [29:0] idx_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        funct3_ok;
    logic        align_ok;
    logic        range_ok;
    logic        req_err;

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [1:0]  a,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'd0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old_w,
                                                input logic [31:0] wd,
                                                input logic [1:0]  a,
                                                input logic [2:0]  f3);
        logic [31:0] w;
        w = old_w;
        case (f3[1:0])
            2'b00: begin
                case (a)
                    2'd0:    w[7:0]   = wd[7:0];
                    2'd1:    w[15:8]  = wd[7:0];
                    2'd2:    w[23:16] = wd[7:0];
                    default: w[31:24] = wd[7:0];
                endcase
            end
            2'b01: begin
                if (a[1]) w[31:16] = wd[15:0];
                else      w[15:0]  = wd[15:0];
            end
            default: w = wd;
        endcase
        store_merge = w;
    endfunction

    // Stores only know B/H/W; loads additionally allow the unsigned B/H forms.
    always_comb begin
        funct3_ok = 1'b0;
        align_ok  = 1'b1;
        case (req_funct3_in)
            3'b000:        funct3_ok = 1'b1;
            3'b001:        funct3_ok = 1'b1;
            3'b010:        funct3_ok = 1'b1;
            3'b100, 3'b101: funct3_ok = !req_we_in;
            default:       funct3_ok = 1'b0;
        endcase
        if (req_funct3_in[1:0] == 2'b01 && req_addr_in[0] != 1'b0)
            align_ok = 1'b0;
        if (req_funct3_in[1:0] == 2'b10 && req_addr_in[1:0] != 2'b00)
            align_ok = 1'b0;
        range_ok = ({2'b00, req_addr_in[31:2]} < DEPTH_WORDS);
        req_err  = !(funct3_ok && align_ok && range_ok);
    end

    always_ff @(posedge clkin or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
            idx_q     <= 30'd0;
            wdata_q   <= 32'd0;
            buf_q     <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_in) begin
                        we_q      <= req_we_in;
                        funct3_q  <= req_funct3_in;
                        addr_lo_q <= req_addr_in[1:0];
                        idx_q     <= req_addr_in[31:2];
                        wdata_q   <= req_wdata_in;
                        rdata_q   <= 32'd0;
                        err_q     <= 1'b0;
                        if (req_err)
                            state_q <= S_ERR;
                        else if (req_we_in && req_funct3_in == 3'b010)
                            state_q <= S_WR;
                        else
                            state_q <= S_RD;
                    end
                end
                S_RD: begin
                    buf_q <= mem_rd_data_in;
                    if (we_q) begin
                        state_q <= S_WR;
                    end else begin
                        rdata_q <= load_ext(mem_rd_data_in, addr_lo_q, funct3_q);
                        state_q <= S_RESP;
                    end
                end
                S_WR: begin
                    state_q <= S_RESP;
                end
                S_ERR: begin
                    err_q   <= 1'b1;
                    rdata_q <= 32'd0;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready_in)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Decoded straight from the state register so reset kills a WR strobe at once.
    assign req_ready_out   = (state_q == S_IDLE);
    assign resp_valid_out  = (state_q == S_RESP);
    assign resp_rdata_out  = rdata_q;
    assign resp_err_out    = err_q;
    assign mem_wr_en_out   = (state_q == S_WR);
    assign mem_wr_addr_out = {2'b00, idx_q};
    assign mem_rd_addr_out = {2'b00, idx_q};
    assign mem_wr_data_out = store_merge(buf_q, wdata_q, addr_lo_q, funct3_q);

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store sequencer between the RV32I execute stage and the word-wide data memory.
- The data memory provides a synchronous word write and a combinational word read, with word-indexed addresses.
- This block turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into memory cycles: read-modify-write for sub-word stores, lane extract plus sign/zero extension for loads.
- It flags misaligned, out-of-range and unsupported accesses; it uses a valid/ready request and response handshake toward the core.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the attached data memory. A word index at or above this value is out of range.

Ports:
- clkin  in  1  clock, rising edge.
- nrst_in  in  1  asynchronous active-low reset.
- req_valid_in  in  1  core request valid.
- req_ready_out  out  1  block can accept a request.
- req_we_in  in  1  1 = store, 0 = load.
- req_funct3_in  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr_in  in  32  byte address.
- req_wdata_in  in  32  store data; the low byte/half is used for SB/SH.
- resp_valid_out  out  1  response valid.
- resp_ready_in  in  1  core accepts the response.
- resp_rdata_out  out  32  extended load data; 0 for stores and errors.
- resp_err_out  out  1  misaligned, out-of-range or illegal funct3.
- mem_wr_en_out  out  1  memory write enable.
- mem_wr_addr_out  out  32  word index (byte address >> 2, zero-extended).
- mem_wr_data_out  out  32  word to write.
- mem_rd_addr_out  out  32  word index for the combinational read.
- mem_rd_data_in  in  32  read data, combinational from mem_rd_addr_out.

Behaviour:
- **Request latch:** a request is accepted on a rising edge with req_valid_in && req_ready_out. At that edge, latch we, funct3, addr, wdata and the word index addr[31:2].
- **Ready:** req_ready_out = (state == IDLE). A new request is never accepted while a response is pending.
- **State: IDLE**
  - On accept, check for errors first: funct3 not in {000, 001, 010, 100, 101} (stores: not in {000, 001, 010}); H with addr[0] != 0; W with addr[1:0] != 0; word index >= DEPTH_WORDS. Any error -> ERR.
  - Otherwise a load or SB/SH -> RD, and SW -> WR.
- **State: RD (one cycle)**
  - mem_rd_addr_out = latched index.
  - At the clock edge, capture mem_rd_data_in into the data buffer.
  - Load -> RESP; SB/SH -> WR.
- **State: WR (one cycle)**
  - mem_wr_en_out = 1 and mem_wr_addr_out = latched index.
  - SW: data = latched wdata.
  - SB: the buffer word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: the buffer word with half lane addr[1] replaced by wdata[15:0].
  - Little-endian: lane 0 = bits [7:0]. Next state RESP.
- **State: ERR (one cycle)** -> RESP with the error flag set. No memory write occurs for an errored request.
- **State: RESP**
  - resp_valid_out = 1.
  - Hold resp_rdata_out and resp_err_out stable until resp_ready_in is high at an edge, then go to IDLE.
- **Load data formation** (registered when leaving RD), using the addressed byte/half of the buffer:
  - LB sign-extends bit 7 of the byte; LBU zero-extends.
  - LH sign-extends bit 15 of the half; LHU zero-extends.
  - LW passes the whole word.
- **Latency** (edges after the accept edge until resp_valid_out is high): load 2, SW 2, SB/SH 3, error 2.
- **Addresses outside RD/WR:** mem_wr_en_out is 0 in every state except WR. mem_wr_addr_out and mem_rd_addr_out always carry the latched index.
- **Reset:**
  - Asynchronous: state = IDLE.
  - Latches, buffer, resp_rdata_out and resp_err_out = 0.
  - resp_valid_out = 0, mem_wr_en_out = 0, req_ready_out = 1 once released.
  - Reset during RD aborts with no write. Reset during WR drops mem_wr_en_out immediately, and no write happens at the next edge.
  - A pending response is discarded.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF:
  - mem_wr_en_out high for exactly one cycle with index 4 and data 0xDEADBEEF.
  - resp_valid_out 2 edges after accept, resp_err_out = 0.
- Word 4 = 0xDEADBEEF:
  - LB addr 0x13 -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x10 -> 0xFFFFBEEF.
  - LHU 0x12 -> 0x0000DEAD.
  - LW 0x10 -> 0xDEADBEEF.
- SB addr 0x11 data 0x55, then SH addr 0x12 data 0x1234 on word 4 = 0xDEADBEEF:
  - Written words are 0xDEAD55EF, then 0x123455EF.
  - Response arrives 3 edges after accept.
- Errors:
  - LW 0x11, SH 0x13, funct3 011, and SW at byte 0x400 (index 256) each give resp_err_out = 1.
  - In every case resp_rdata_out = 0 and mem_wr_en_out is never asserted.
- Response backpressure: hold resp_ready_in = 0 for 5 cycles.
  - resp_valid_out and the data stay stable, req_ready_out stays 0, and a new req_valid_in is ignored.
  - The block returns to IDLE on the edge after resp_ready_in rises.
- Reset asserted in the WR cycle of an SB:
  - mem_wr_en_out goes low asynchronously and the memory word is unchanged.
  - After release req_ready_out = 1 and resp_valid_out = 0.
